// File: rtl/gcd_xcel_core.sv
// gcd_xcel_core: single-transaction iterative GCD engine (Euclid subtract/swap).
// A request {a, b} is accepted in IDLE. CALC performs one swap or subtract per
// cycle until b reaches zero. DONE holds the result until the response is taken.
// Optional feature macro: GCD_ZERO_BYPASS_EN. When it is defined, a zero operand
// at accept goes straight to DONE with a|b as the result.
module gcd_xcel_core #(
  parameter int unsigned p_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic [2*p_nbits-1:0]   req_msg,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic [p_nbits-1:0]     resp_msg
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [p_nbits-1:0] a_q, a_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] req_a, req_b;

  assign req_a = req_msg[2*p_nbits-1:p_nbits];
  assign req_b = req_msg[p_nbits-1:0];

  // State and operand registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Next-state and datapath update: one Euclid step per CALC cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      StIdle: begin
        // req_rdy is high whenever the registers can change in IDLE.
        if (req_val) begin
          a_d     = req_a;
          b_d     = req_b;
          state_d = StCalc;
`ifdef GCD_ZERO_BYPASS_EN
          if ((req_a == '0) || (req_b == '0)) begin
            a_d     = req_a | req_b;
            b_d     = '0;
            state_d = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else if (b_q != '0) begin
          a_d = a_q - b_q;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (resp_rdy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs are pure functions of state; req_rdy is also gated by reset.
  always_comb begin
    req_rdy  = (state_q == StIdle) && !reset;
    resp_val = (state_q == StDone);
    resp_msg = (state_q == StDone) ? a_q : '0;
  end

endmodule

// File: tb/tb_gcd_xcel_core.sv
// Self-checking bench for gcd_xcel_core: directed vector table, reset corner
// cases and randomized transactions against a Euclid reference model.
module tb_gcd_xcel_core;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_val;
  logic           req_rdy;
  logic [2*W-1:0] req_msg;
  logic           resp_val;
  logic           resp_rdy;
  logic [W-1:0]   resp_msg;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_xcel_core #(.p_nbits(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int unsigned  k;    // CALC cycles, including the final b==0 cycle
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference result: modulo-based Euclid.
  function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtract/swap steps plus the terminating b==0 step.
  function automatic int unsigned ref_steps(input int unsigned a, input int unsigned b);
    int unsigned n;
    int unsigned t;
    n = 1;
    while (b != 0) begin
      if (a < b) begin
        t = a;
        a = b;
        b = t;
      end else begin
        a = a - b;
      end
      n++;
    end
    return n;
  endfunction

  // Posedges after the accept edge until resp_val is visible.
  function automatic int unsigned exp_lat(input int unsigned a, input int unsigned b,
                                          input int unsigned k);
`ifdef GCD_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 0;
`endif
    return k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one transaction; req_val is driven with junk while busy to expose early accepts.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int src_dly, input int sink_dly,
                        output logic [W-1:0] res, output int lat,
                        output bit busy_ok, output bit timed_out);
    int g;
    busy_ok   = 1'b1;
    timed_out = 1'b0;
    lat       = 0;
    res       = '0;
    req_val   = 1'b0;
    repeat (src_dly) step();
    req_msg = {a, b};
    req_val = 1'b1;
    g = 0;
    while (!req_rdy && g < 100) begin
      step();
      g++;
    end
    if (!req_rdy) begin
      timed_out = 1'b1;
      req_val   = 1'b0;
      return;
    end
    step();
    req_msg = $urandom;
    req_val = 1'b1;
    while (!resp_val && lat < 5000) begin
      if (req_rdy) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (!resp_val) begin
      timed_out = 1'b1;
      req_val   = 1'b0;
      return;
    end
    res = resp_msg;
    repeat (sink_dly) begin
      if (req_rdy || !resp_val || resp_msg !== res) busy_ok = 1'b0;
      step();
    end
    req_val  = 1'b0;
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    if (!req_rdy || resp_val || resp_msg !== '0) busy_ok = 1'b0;
  endtask

  initial begin
    logic [W-1:0] res;
    logic [W-1:0] ra, rb;
    int           lat;
    bit           busy_ok, tmo;
    int           seen;

    vecs[0] = '{a: 16'd15,    b: 16'd5,     res: 16'd5,     k: 5};
    vecs[1] = '{a: 16'd0,     b: 16'd7,     res: 16'd7,     k: 2};
    vecs[2] = '{a: 16'd7,     b: 16'd0,     res: 16'd7,     k: 1};
    vecs[3] = '{a: 16'd0,     b: 16'd0,     res: 16'd0,     k: 1};
    vecs[4] = '{a: 16'd9,     b: 16'd9,     res: 16'd9,     k: 3};
    vecs[5] = '{a: 16'hFFFF,  b: 16'hFFFF,  res: 16'hFFFF,  k: 3};
    vecs[6] = '{a: 16'd27,    b: 16'd15,    res: 16'd3,     k: 10};
    vecs[7] = '{a: 16'd12,    b: 16'd18,    res: 16'd6,     k: 7};
    vecs[8] = '{a: 16'd100,   b: 16'd75,    res: 16'd25,    k: 7};

    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b0;

    // Reset held and released.
    #1;
    check("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("rst_resp_msg", {16'd0, resp_msg}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_req_rdy", {31'd0, req_rdy}, 32'd1);
    check("idle_resp_val", {31'd0, resp_val}, 32'd0);
    check("idle_resp_msg", {16'd0, resp_msg}, 32'd0);
    step();

    // Directed vectors.
    foreach (vecs[i]) begin
      do_txn(vecs[i].a, vecs[i].b, 0, (i == 6) ? 10 : 0, res, lat, busy_ok, tmo);
      check($sformatf("vec%0d_timeout", i), {31'd0, tmo}, 32'd0);
      check($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].res});
      check($sformatf("vec%0d_latency", i), lat,
            exp_lat(vecs[i].a, vecs[i].b, vecs[i].k));
      check($sformatf("vec%0d_busy_hold", i), {31'd0, busy_ok}, 32'd1);
    end

    // Reset during CALC: outputs clear at once and no response follows.
    req_msg = {16'd200, 16'd3};
    req_val = 1'b1;
    step();
    req_val = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    check("midcalc_rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    check("midcalc_rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("midcalc_rst_resp_msg", {16'd0, resp_msg}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midcalc_post_req_rdy", {31'd0, req_rdy}, 32'd1);
    seen = 0;
    repeat (20) begin
      step();
      if (resp_val) seen++;
    end
    check("midcalc_no_resp", seen, 0);

    // Reset while a result waits in DONE.
    req_msg = {16'd15, 16'd5};
    req_val = 1'b1;
    step();
    req_val = 1'b0;
    repeat (5) step();
    check("done_before_rst", {15'd0, resp_val, resp_msg}, {15'd0, 1'b1, 16'd5});
    #2 reset = 1'b1;
    #1;
    check("done_rst_resp_val", {31'd0, resp_val}, 32'd0);
    check("done_rst_resp_msg", {16'd0, resp_msg}, 32'd0);
    #2 reset = 1'b0;
    step();
    seen = 0;
    repeat (10) begin
      if (resp_val) seen++;
      step();
    end
    check("done_rst_no_resp", seen, 0);

    // Fresh transaction after reset.
    do_txn(16'd15, 16'd5, 0, 0, res, lat, busy_ok, tmo);
    check("post_rst_result", {16'd0, res}, 32'd5);
    check("post_rst_latency", lat, exp_lat(15, 5, 5));

    // Randomized transactions against the reference model.
    for (int t = 0; t < 1000; t++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) ra = '0;
      if ($urandom_range(0, 15) == 0) rb = '0;
      do_txn(ra, rb, $urandom_range(0, 8), $urandom_range(0, 8), res, lat, busy_ok, tmo);
      check($sformatf("rnd%0d_timeout a=%0d b=%0d", t, ra, rb), {31'd0, tmo}, 32'd0);
      if (!tmo) begin
        check($sformatf("rnd%0d_result a=%0d b=%0d", t, ra, rb), {16'd0, res},
              ref_gcd(ra, rb));
        check($sformatf("rnd%0d_latency a=%0d b=%0d", t, ra, rb), lat,
              exp_lat(ra, rb, ref_steps(ra, rb)));
        check($sformatf("rnd%0d_busy_hold", t), {31'd0, busy_ok}, 32'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
